turfio_rxclk_ps_ctrl: RTL and testbench
=======================================

Name: turfio_rxclk_ps_ctrl

Overview:
Dynamic phase-shift initiator for the TURFIO RXCLK MMCM on the SURF. Accepts "advance N fine steps" requests from the alignment/register logic and drives the MMCM PSEN/PSDONE handshake one step at a time (increment only).
Tracks the cumulative phase position modulo one RXCLK period. Detects a missing PSDONE (timeout) and loss of MMCM lock.

Parameters:
STEP_WIDTH, 10, width of request count and phase position; must hold PERIOD_STEPS-1.
PERIOD_STEPS, 672, fine steps per RXCLK period (56 steps per VCO period x VCO multiplier 12).
TIMEOUT_CYCLES, 63, max clk_i cycles to wait for PSDONE after PSEN.
GAP_CYCLES, 2, idle cycles between a PSDONE and the next PSEN.

Ports:
clk_i  in  1  phase-shift clock; the same clock drives MMCM PSCLK.
rst_i  in  1  synchronous, active-high reset.
locked_i  in  1  MMCM LOCKED, already synchronous to clk_i.
req_steps_i  in  STEP_WIDTH  number of increments requested.
req_valid_i  in  1  request valid.
req_ready_o  out  1  block can accept a request.
ps_en_o  out  1  MMCM PSEN.
ps_done_i  in  1  MMCM PSDONE.
busy_o  out  1  request in progress.
done_o  out  1  one-cycle pulse when a request completes normally.
phase_o  out  STEP_WIDTH  current position, 0..PERIOD_STEPS-1.
err_o  out  1  sticky error.
err_cause_o  out  2  01 = PSDONE timeout; 10 = lock lost; 00 = none.
clr_err_i  in  1  clears err_o and err_cause_o.

Behaviour:
- Reset values: ps_en_o=0, busy_o=0, done_o=0, phase_o=0, err_o=0, err_cause_o=00, state=IDLE.
- req_ready_o = (state==IDLE) && locked_i && !err_o. This is combinational from registered state.
- A request is accepted when req_valid_i && req_ready_o. On acceptance, latch remaining = req_steps_i and set busy_o=1 from the next cycle.
- States:
  - IDLE.
  - ISSUE: ps_en_o=1 for exactly this one cycle; load the timeout counter; always go to WAIT.
  - WAIT: count cycles.
  - GAP: count GAP_CYCLES.
  - FIN: done_o=1 for one cycle; then IDLE.
- Transitions:
  - IDLE -> ISSUE on acceptance with req_steps_i!=0.
  - IDLE -> FIN on acceptance with req_steps_i==0. No PSEN is issued; done_o is asserted the cycle after acceptance.
  - WAIT, on ps_done_i: phase_o increments; remaining decrements. Go to FIN if remaining was 1, else to GAP.
  - GAP -> ISSUE after GAP_CYCLES cycles.
  - WAIT with no ps_done_i for TIMEOUT_CYCLES cycles: err_o=1, err_cause_o=01, go to IDLE. No done_o; phase_o unchanged.
- Latency: acceptance at cycle 0 gives PSEN at cycle 1. PSDONE at cycle k gives the next PSEN at k+GAP_CYCLES+1.
- Phase wrap: phase_o == PERIOD_STEPS-1 plus one step gives 0. No carry/flag.
- ps_done_i outside WAIT (including coincident with ps_en_o) is ignored. It has no effect on phase_o or err_o.
- Lock loss: locked_i==0 in any state clears phase_o to 0, because the MMCM reset zeroes the shift. If busy, it also aborts to IDLE, drops ps_en_o, sets err_o=1 with err_cause_o=10, and suppresses done_o. If idle, it clears phase_o with no error.
- clr_err_i clears err_o/err_cause_o in any state. If a new error occurs in the same cycle, the new error wins.
- rst_i mid-operation: immediate return to reset values next cycle; any outstanding PSDONE is ignored.
- The timeout counter width is clog2(TIMEOUT_CYCLES+1). The GAP counter is sized similarly. remaining is STEP_WIDTH bits.

Decomposition:
- Package turfio_ps_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, GAP, FIN);
  - the error-cause codes (ERR_NONE, ERR_TIMEOUT, ERR_UNLOCK);
  - the MMCM constants: FINE_STEPS_PER_VCO=56, VCO_MULT=12, PERIOD_STEPS derived from them.
- Single module, no sub-module. The timeout and gap counters are too small to justify one.

Test Plan:
- Basic: locked_i=1, request 3 steps, PSDONE modelled 12 cycles after each PSEN -> three PSEN pulses spaced 12+GAP_CYCLES+1 cycles, phase_o=3, one done_o pulse, busy_o low afterwards.
- Wrap: request 670 steps, then 5 steps -> phase_o=670, then 3 (675 mod 672); exactly 5 PSEN in the second request.
- Zero request: req_steps_i=0 -> done_o the cycle after acceptance, no PSEN, phase_o unchanged.
- Timeout: model withholds PSDONE on the 2nd step of a 4-step request -> err_o=1, err_cause_o=01 exactly TIMEOUT_CYCLES cycles after that PSEN, phase_o=1, no done_o, req_ready_o=0 until clr_err_i pulse.
- Lock loss: drop locked_i mid-request after 2 steps (phase_o was 10 beforehand) -> next cycle phase_o=0, err_cause_o=10, ps_en_o=0, IDLE; a late PSDONE is ignored.
- Reset/spurious: PSDONE pulses while IDLE -> no phase change. rst_i during WAIT -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/turfio_ps_pkg.sv
// Shared types and MMCM constants for the TURFIO RXCLK dynamic phase-shift controller.
package turfio_ps_pkg;

  // Controller states: one PSEN per ISSUE, PSDONE awaited in WAIT, spacing in GAP.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_GAP   = 3'd3,
    ST_FIN   = 3'd4
  } ps_state_t;

  // Sticky error cause reported alongside err_o.
  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_TIMEOUT = 2'b01,
    ERR_UNLOCK  = 2'b10
  } err_cause_t;

  // One VCO period is 56 fine steps; RXCLK runs at VCO/12, so a full RXCLK
  // period is 672 fine steps.
  localparam int FINE_STEPS_PER_VCO = 56;
  localparam int VCO_MULT           = 12;
  localparam int MMCM_PERIOD_STEPS  = FINE_STEPS_PER_VCO * VCO_MULT;

endpackage

// File: rtl/turfio_rxclk_ps_ctrl.sv
// Dynamic phase-shift initiator for the TURFIO RXCLK MMCM: issues increment-only
// PSEN/PSDONE handshakes one at a time, tracks the phase modulo one RXCLK period,
// and flags a missing PSDONE or loss of MMCM lock.
module turfio_rxclk_ps_ctrl
  import turfio_ps_pkg::*;
#(
  parameter int STEP_WIDTH     = 10,
  parameter int PERIOD_STEPS   = MMCM_PERIOD_STEPS,
  parameter int TIMEOUT_CYCLES = 63,
  parameter int GAP_CYCLES     = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  locked_i,
  input  logic [STEP_WIDTH-1:0] req_steps_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  output logic                  ps_en_o,
  input  logic                  ps_done_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [STEP_WIDTH-1:0] phase_o,
  output logic                  err_o,
  output logic [1:0]            err_cause_o,
  input  logic                  clr_err_i
);

  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  ps_state_t             state_r,     state_s;
  logic [STEP_WIDTH-1:0] phase_r,     phase_s;
  logic [STEP_WIDTH-1:0] remaining_r, remaining_s;
  logic [TO_W-1:0]       to_cnt_r,    to_cnt_s;
  logic [GAP_W-1:0]      gap_cnt_r,   gap_cnt_s;
  logic                  err_r,       err_s;
  err_cause_t            cause_r,     cause_s;
  logic                  ps_en_r,     ps_en_s;
  logic                  done_r,      done_s;
  logic                  busy_r,      busy_s;
  logic                  accept_s;

  // Advance the phase by one fine step, wrapping at one RXCLK period.
  function automatic logic [STEP_WIDTH-1:0] phase_inc(input logic [STEP_WIDTH-1:0] p);
    if (p == STEP_WIDTH'(PERIOD_STEPS - 1)) begin
      return '0;
    end else begin
      return p + STEP_WIDTH'(1);
    end
  endfunction

  assign req_ready_o = (state_r == ST_IDLE) && locked_i && !err_r;
  assign accept_s    = req_valid_i && req_ready_o;

  assign ps_en_o     = ps_en_r;
  assign done_o      = done_r;
  assign busy_o      = busy_r;
  assign phase_o     = phase_r;
  assign err_o       = err_r;
  assign err_cause_o = cause_r;

  // Next-state, counter, phase and error computation; lock loss overrides the FSM.
  always_comb begin
    state_s     = state_r;
    phase_s     = phase_r;
    remaining_s = remaining_r;
    to_cnt_s    = to_cnt_r;
    gap_cnt_s   = gap_cnt_r;
    err_s       = err_r;
    cause_s     = cause_r;

    // Clearing happens first so that an error raised below in the same cycle wins.
    if (clr_err_i) begin
      err_s   = 1'b0;
      cause_s = ERR_NONE;
    end else begin
      err_s   = err_r;
      cause_s = cause_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          remaining_s = req_steps_i;
          state_s     = (req_steps_i != '0) ? ST_ISSUE : ST_FIN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // The PSEN cycle itself counts as the first cycle spent waiting.
        to_cnt_s = TO_W'(1);
        state_s  = ST_WAIT;
      end
      ST_WAIT: begin
        if (ps_done_i) begin
          phase_s     = phase_inc(phase_r);
          remaining_s = remaining_r - STEP_WIDTH'(1);
          if (remaining_r == STEP_WIDTH'(1)) begin
            state_s = ST_FIN;
          end else begin
            state_s   = ST_GAP;
            gap_cnt_s = GAP_W'(GAP_CYCLES - 1);
          end
        end else if (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1)) begin
          err_s   = 1'b1;
          cause_s = ERR_TIMEOUT;
          state_s = ST_IDLE;
        end else begin
          to_cnt_s = to_cnt_r + TO_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == GAP_W'(0)) begin
          state_s = ST_ISSUE;
        end else begin
          gap_cnt_s = gap_cnt_r - GAP_W'(1);
        end
      end
      ST_FIN: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // An MMCM reset zeroes the applied shift; an in-flight request is abandoned.
    if (!locked_i) begin
      phase_s = '0;
      if (state_r != ST_IDLE) begin
        state_s = ST_IDLE;
        err_s   = 1'b1;
        cause_s = ERR_UNLOCK;
      end else begin
        state_s = ST_IDLE;
      end
    end else begin
      phase_s = phase_s;
    end

    ps_en_s = (state_s == ST_ISSUE);
    done_s  = (state_s == ST_FIN);
    busy_s  = (state_s != ST_IDLE);
  end

  // State, datapath and registered outputs with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= ST_IDLE;
      phase_r     <= '0;
      remaining_r <= '0;
      to_cnt_r    <= '0;
      gap_cnt_r   <= '0;
      err_r       <= 1'b0;
      cause_r     <= ERR_NONE;
      ps_en_r     <= 1'b0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      phase_r     <= phase_s;
      remaining_r <= remaining_s;
      to_cnt_r    <= to_cnt_s;
      gap_cnt_r   <= gap_cnt_s;
      err_r       <= err_s;
      cause_r     <= cause_s;
      ps_en_r     <= ps_en_s;
      done_r      <= done_s;
      busy_r      <= busy_s;
    end
  end

endmodule

// File: tb/tb_turfio_rxclk_ps_ctrl.sv
// Self-checking bench for turfio_rxclk_ps_ctrl: table-driven requests with a
// scoreboard, plus hand sequences for timeout, lock loss, spurious PSDONE and reset.
module tb_turfio_rxclk_ps_ctrl;
  import turfio_ps_pkg::*;

  localparam int SW  = 10;
  localparam int PER = 672;
  localparam int TO  = 63;
  localparam int GAP = 2;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          locked_i;
  logic [SW-1:0] req_steps_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic          ps_en_o;
  logic          ps_done_i;
  logic          busy_o;
  logic          done_o;
  logic [SW-1:0] phase_o;
  logic          err_o;
  logic [1:0]    err_cause_o;
  logic          clr_err_i;

  logic reply_r = 1'b0;
  logic spur    = 1'b0;
  assign ps_done_i = reply_r | spur;

  turfio_rxclk_ps_ctrl #(
    .STEP_WIDTH(SW), .PERIOD_STEPS(PER), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .locked_i(locked_i), .req_steps_i(req_steps_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .ps_en_o(ps_en_o),
    .ps_done_i(ps_done_i), .busy_o(busy_o), .done_o(done_o), .phase_o(phase_o),
    .err_o(err_o), .err_cause_o(err_cause_o), .clr_err_i(clr_err_i)
  );

  initial forever #5 clk = ~clk;

  typedef struct { int steps; int delay; int exp_phase; } vec_t;
  typedef struct { int phase; int psen; } exp_t;

  int   tests_run    = 0;
  int   tests_failed = 0;
  int   cyc          = 0;
  int   psen_total   = 0;
  int   done_total   = 0;
  int   done_cyc     = -1;
  int   resp_delay   = 12;
  int   resp_cnt     = 0;
  int   withhold_at  = -1;
  int   psen_q[$];
  exp_t sb_q[$];
  vec_t vecs[5];

  // Cycle counter: during the cycle after posedge N, cyc equals N.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // MMCM model: answers each PSEN with PSDONE resp_delay cycles later (unless withheld)
  // and records PSEN / done_o activity.
  initial forever begin
    @(negedge clk);
    if (resp_cnt > 0) begin
      resp_cnt--;
      reply_r = (resp_cnt == 0);
    end else begin
      reply_r = 1'b0;
    end
    if (ps_en_o === 1'b1) begin
      psen_total++;
      psen_q.push_back(cyc);
      resp_cnt = (psen_total == withhold_at) ? 0 : resp_delay;
    end
    if (done_o === 1'b1) begin
      done_total++;
      done_cyc = cyc;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_request(input int steps, output int acc);
    int g;
    g = 0;
    @(negedge clk);
    while (!req_ready_o && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("req_ready_wait", int'(req_ready_o), 1);
    req_valid_i = 1'b1;
    req_steps_i = SW'(steps);
    acc = cyc;
    @(negedge clk);
    req_valid_i = 1'b0;
  endtask

  task automatic run_req(input int steps, input int delay, input int exp_phase, input string tag);
    exp_t e;
    int   acc, p0, d0, g, lat, bad;
    resp_delay = delay;
    p0 = psen_total;
    d0 = done_total;
    psen_q.delete();
    do_request(steps, acc);
    e.phase = exp_phase;
    e.psen  = steps;
    sb_q.push_back(e);
    g = 0;
    while (done_total == d0 && g < steps * (delay + GAP + 3) + 50) begin
      @(negedge clk);
      g++;
    end
    e = sb_q.pop_front();
    chk($sformatf("%s_done_count", tag), done_total - d0, 1);
    if (done_total != d0) begin
      if (cyc == done_cyc) @(negedge clk);
      chk($sformatf("%s_phase", tag), int'(phase_o), e.phase);
      chk($sformatf("%s_psen_count", tag), psen_total - p0, e.psen);
      if (steps == 0) lat = done_cyc - acc;
      else if (psen_q.size() > 0) lat = psen_q[0] - acc;
      else lat = -1;
      chk($sformatf("%s_latency", tag), lat, 1);
      bad = 0;
      for (int i = 1; i < psen_q.size(); i++) begin
        if (psen_q[i] - psen_q[i-1] != delay + GAP + 1) bad++;
      end
      chk($sformatf("%s_psen_spacing_errs", tag), bad, 0);
      chk($sformatf("%s_busy_after", tag), int'(busy_o), 0);
      chk($sformatf("%s_err", tag), int'(err_o), 0);
    end
  endtask

  initial begin
    int acc, p0, d0, g, target, e_cyc;

    vecs[0] = '{steps: 3,   delay: 12, exp_phase: 3};
    vecs[1] = '{steps: 0,   delay: 12, exp_phase: 3};
    vecs[2] = '{steps: 667, delay: 1,  exp_phase: 670};
    vecs[3] = '{steps: 5,   delay: 12, exp_phase: 3};
    vecs[4] = '{steps: 4,   delay: 2,  exp_phase: 7};

    rst_i = 1'b1; locked_i = 1'b1; req_steps_i = '0; req_valid_i = 1'b0; clr_err_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ps_en", int'(ps_en_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_phase", int'(phase_o), 0);
    chk("rst_err", int'(err_o), 0);
    chk("rst_cause", int'(err_cause_o), int'(ERR_NONE));
    rst_i = 1'b0;
    @(negedge clk);
    chk("rst_ready", int'(req_ready_o), 1);

    for (int i = 0; i < 5; i++) begin
      run_req(vecs[i].steps, vecs[i].delay, vecs[i].exp_phase, $sformatf("vec%0d", i));
    end

    // PSDONE pulses while idle must not move the phase.
    d0 = done_total; p0 = psen_total;
    spur = 1'b1;
    repeat (3) @(negedge clk);
    spur = 1'b0;
    @(negedge clk);
    chk("spur_idle_phase", int'(phase_o), 7);
    chk("spur_idle_err", int'(err_o), 0);
    chk("spur_idle_done", done_total - d0, 0);

    // PSDONE coincident with PSEN is ignored; the real reply 3 cycles later counts.
    resp_delay = 3;
    d0 = done_total;
    do_request(1, acc);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    g = 0;
    while (done_total == d0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("coinc_done", done_total - d0, 1);
    chk("coinc_phase", int'(phase_o), 8);

    // Timeout: second PSDONE of a 4-step request withheld.
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    chk("to_pre_phase", int'(phase_o), 0);
    psen_q.delete();
    d0 = done_total;
    withhold_at = psen_total + 2;
    resp_delay = 12;
    do_request(4, acc);
    g = 0;
    while (!err_o && g < 400) begin
      @(negedge clk);
      g++;
    end
    e_cyc = cyc;
    chk("to_err", int'(err_o), 1);
    chk("to_psen_count", psen_q.size(), 2);
    chk("to_latency", (psen_q.size() >= 2) ? e_cyc - psen_q[1] : -1, TO);
    chk("to_cause", int'(err_cause_o), int'(ERR_TIMEOUT));
    chk("to_phase", int'(phase_o), 1);
    chk("to_no_done", done_total - d0, 0);
    chk("to_busy", int'(busy_o), 0);
    withhold_at = -1;
    repeat (5) @(negedge clk);
    chk("to_ready_blocked", int'(req_ready_o), 0);
    clr_err_i = 1'b1;
    @(negedge clk);
    clr_err_i = 1'b0;
    chk("clr_err", int'(err_o), 0);
    chk("clr_cause", int'(err_cause_o), int'(ERR_NONE));
    chk("clr_ready", int'(req_ready_o), 1);

    // Lock loss mid-request after two completed steps.
    run_req(7, 1, 8, "prelock");
    resp_delay = 12;
    psen_q.delete();
    d0 = done_total; p0 = psen_total;
    do_request(5, acc);
    g = 0;
    while (psen_q.size() < 3 && g < 200) begin
      @(negedge clk);
      g++;
    end
    target = (psen_q.size() >= 3) ? psen_q[2] + 1 : cyc;
    while (cyc < target) @(negedge clk);
    chk("lock_pre_phase", int'(phase_o), 10);
    locked_i = 1'b0;
    @(negedge clk);
    chk("lock_phase", int'(phase_o), 0);
    chk("lock_err", int'(err_o), 1);
    chk("lock_cause", int'(err_cause_o), int'(ERR_UNLOCK));
    chk("lock_ps_en", int'(ps_en_o), 0);
    chk("lock_busy", int'(busy_o), 0);
    locked_i = 1'b1;
    repeat (16) @(negedge clk);
    chk("lock_late_phase", int'(phase_o), 0);
    chk("lock_no_done", done_total - d0, 0);
    chk("lock_psen_count", psen_total - p0, 3);
    chk("lock_cause_held", int'(err_cause_o), int'(ERR_UNLOCK));
    clr_err_i = 1'b1;
    @(negedge clk);
    clr_err_i = 1'b0;

    // Reset during WAIT: reset values next cycle, late PSDONE ignored.
    psen_q.delete();
    d0 = done_total; p0 = psen_total;
    run_req(2, 1, 2, "prerst");
    psen_q.delete();
    d0 = done_total; p0 = psen_total;
    resp_delay = 12;
    do_request(3, acc);
    g = 0;
    while (psen_q.size() < 1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    target = (psen_q.size() >= 1) ? psen_q[0] + 1 : cyc;
    while (cyc < target) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    chk("mrst_ps_en", int'(ps_en_o), 0);
    chk("mrst_busy", int'(busy_o), 0);
    chk("mrst_done", int'(done_o), 0);
    chk("mrst_phase", int'(phase_o), 0);
    chk("mrst_err", int'(err_o), 0);
    chk("mrst_cause", int'(err_cause_o), int'(ERR_NONE));
    rst_i = 1'b0;
    repeat (15) @(negedge clk);
    chk("mrst_late_phase", int'(phase_o), 0);
    chk("mrst_no_done", done_total - d0, 0);
    chk("mrst_psen_count", psen_total - p0, 1);
    chk("mrst_ready", int'(req_ready_o), 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
